aes128_inv_core: RTL
====================

// Module: aes128_inv_core
// PURPOSE
//  Iterative AES-128 decryption core (FIPS-197 inverse cipher), the receive-side counterpart of AES128_core.
//  Same word-serial interface: 4x32-bit ciphertext and key words in, 4x32-bit plaintext words out.
//  Expands the cipher key forward, then applies round keys 10..0 one inverse round per clock.
// PARAMETERS
//  DATA_WIDTH  32  word width of ciphertext_in/key_in/data_out; only 32 is supported.
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  ciphertext_in  in   32  ciphertext word, first word = bits [127:96]
//  key_in         in   32  cipher key word, same ordering as ciphertext_in
//  MP_dv_in       in   1   ciphertext_in/key_in valid this cycle
//  data_out       out  32  plaintext word, MSW first; 0 when core_dv_out low
//  core_dv_out    out  1   data_out valid
//  busy_out       out  1   high from 4th accepted word until last output word
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, word count 0, round-key regs 0, cache valid 0. Reset mid-op aborts silently.
//  FSM: IDLE/LOAD -> KEYEXP -> ROUND -> OUTPUT -> IDLE.
//   LOAD: each cycle with MP_dv_in=1 shifts one ct/key word in; gaps allowed (count holds). 4th word -> KEYEXP.
//   MP_dv_in while busy_out=1 is ignored; no words are captured.
//   KEYEXP: 10 cycles; cycle i produces rk[i] (i=1..10) from rk[i-1] using SubWord/RotWord/Rcon[i];
//    on the 10th cycle state <= ct ^ rk10.
//   ROUND: 10 cycles, r=9..0: InvShiftRows, InvSubBytes, AddRoundKey(rk[r]), InvMixColumns (omitted when r=0).
//   OUTPUT: 4 cycles, core_dv_out=1, data_out = pt[127:96], [95:64], [63:32], [31:0]; then IDLE.
//  Latency: 4th input word sampled at edge T -> core_dv_out rises at edge T+21, falls at T+25.
//  New input accepted from the cycle after core_dv_out falls; back-to-back blocks have no other dead cycle.
//  All byte ops GF(2^8) mod x^8+x^4+x^3+x+1; InvMixColumns coefficients {0e,0b,0d,09}.
// CONFIGURATION
//  AES_KEY_CACHE_EN defined: rk[0..10] and a cache-valid flag are kept after a block. If the 4 loaded key
//   words equal rk[0] and the cache is valid, KEYEXP is skipped and state <= ct ^ rk10 at edge T.
//   Latency is then T+11. A key mismatch clears the cache and runs KEYEXP as normal. Reset clears the cache.
//  Not defined: KEYEXP always runs, latency is always T+21, and there is no cache-valid flag.
// STRUCTURE
//  Package aes128_pkg holds the sbox() and inv_sbox() functions, the RCON[1:10] constant,
//   the xtime/gmul functions and the FSM state enum.
//  Sub-module aes128_inv_round: combinational inverse round (state, rk, last_round) -> next state.
//  Top holds the FSM, load shifter, key-expansion datapath, rk[0:10] array and output shifter.
// TESTING
//  1 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a
//    -> pt 00112233445566778899aabbccddeeff on 4 consecutive core_dv_out cycles, first at T+21.
//  2 Team vector: key 5468617473204d79204b756e67204675, ct 6f5ddb7f39560b0fe9eada49f87c4904
//    -> pt 416476616e63656420456e6372797074.
//  3 Vector 2 loaded with 2-cycle MP_dv_in gaps between words, plus extra MP_dv_in pulses during ROUND
//    -> same pt, latency counted from the 4th word, extra pulses ignored.
//  4 rst_n pulsed low in the middle of ROUND -> outputs 0 immediately; vector 1 rerun afterwards passes.
//  5 AES_KEY_CACHE_EN: vector 2 twice, same key -> 2nd block core_dv_out at T+11.
//    Then vector 1 (new key) -> T+21, correct pt.
//  6 Back-to-back: vector 1 loaded on the cycle after core_dv_out falls -> correct pt, no lost words.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-box / inverse S-box, round constants and FSM states.
package aes128_pkg;

  typedef enum logic [2:0] {IDLE_S, LOAD_S, KEYEXP_S, ROUND_S, OUTPUT_S} fsm_e;

  localparam logic [1:10][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

endpackage

// File: rtl/aes128_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes128_inv_round
  import aes128_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] state_out
);

  // byte index 4*col+row, byte 0 in bits [127:120]
  logic [0:15][7:0] s, k, t, m;

  assign s = state_in;
  assign k = rk;

  always_comb begin
    t = '0;
    m = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = inv_sbox(s[4*((c - r + 4) % 4) + r]) ^ k[4*c+r];
    for (int c = 0; c < 4; c++) begin
      m[4*c+0] = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
      m[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
      m[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
      m[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
    end
  end

  assign state_out = last_round ? t : m;

endmodule

// File: rtl/aes128_inv_core.sv
// Iterative AES-128 decryption core, word-serial in/out, one inverse round per clock.
// Optional AES_KEY_CACHE_EN keeps the round keys and skips expansion when the same key is reloaded.
module aes128_inv_core
  import aes128_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ciphertext_in,
  input  logic [DATA_WIDTH-1:0] key_in,
  input  logic                  MP_dv_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  core_dv_out,
  output logic                  busy_out
);

  fsm_e         fsm, fsm_nxt;
  logic [3:0]   cnt;
  logic [127:0] state;
  logic [95:0]  key_sh;
  logic [127:0] rk [0:10];
  logic [127:0] kexp_nxt, round_nxt, rk_sel;
  logic         accept, last_word, cache_hit;

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign accept    = MP_dv_in && (fsm == IDLE_S || fsm == LOAD_S);
  assign last_word = accept && (cnt == 4'd3);
  assign busy_out  = (fsm == KEYEXP_S) || (fsm == ROUND_S) || (fsm == OUTPUT_S);
  assign kexp_nxt  = key_step(rk[cnt - 4'd1], RCON[cnt]);
  assign rk_sel    = rk[cnt];

`ifdef AES_KEY_CACHE_EN
  logic cache_vld;
  assign cache_hit = cache_vld && ({key_sh, key_in} == rk[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cache_vld <= 1'b0;
    else if (last_word && !cache_hit)        cache_vld <= 1'b0;
    else if (fsm == KEYEXP_S && cnt == 4'd10) cache_vld <= 1'b1;
  end
`else
  assign cache_hit = 1'b0;
`endif

  aes128_inv_round u_round (
    .state_in  (state),
    .rk        (rk_sel),
    .last_round(cnt == 4'd0),
    .state_out (round_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE_S;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE_S, LOAD_S: begin
        if (last_word)   fsm_nxt = cache_hit ? ROUND_S : KEYEXP_S;
        else if (accept) fsm_nxt = LOAD_S;
      end
      KEYEXP_S: if (cnt == 4'd10) fsm_nxt = ROUND_S;
      ROUND_S:  if (cnt == 4'd0)  fsm_nxt = OUTPUT_S;
      OUTPUT_S: if (cnt == 4'd3)  fsm_nxt = IDLE_S;
      default:  fsm_nxt = IDLE_S;
    endcase
  end

  // cnt: word count in LOAD, key index in KEYEXP, round index in ROUND, word index in OUTPUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      state       <= '0;
      key_sh      <= '0;
      data_out    <= '0;
      core_dv_out <= 1'b0;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
    end else begin
      core_dv_out <= (fsm == OUTPUT_S);
      data_out    <= (fsm == OUTPUT_S) ? state[127:96] : '0;
      case (fsm)
        IDLE_S, LOAD_S: begin
          if (accept) begin
            state  <= {state[95:0], ciphertext_in};
            key_sh <= {key_sh[63:0], key_in};
            cnt    <= cnt + 4'd1;
            if (last_word) begin
              if (cache_hit) begin
                state <= {state[95:0], ciphertext_in} ^ rk[10];
                cnt   <= 4'd9;
              end else begin
                rk[0] <= {key_sh, key_in};
                cnt   <= 4'd1;
              end
            end
          end
        end
        KEYEXP_S: begin
          rk[cnt] <= kexp_nxt;
          if (cnt == 4'd10) begin
            state <= state ^ kexp_nxt;
            cnt   <= 4'd9;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND_S: begin
          state <= round_nxt;
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        OUTPUT_S: begin
          state <= {state[95:0], 32'h0};
          cnt   <= (cnt == 4'd3) ? 4'd0 : cnt + 4'd1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
